master_tx_sequencer: RTL and testbench
======================================

MASTER_TX_SEQUENCER -- requirements
Module: master_tx_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle clk cycles inserted between consecutive words.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: maximum clk cycles to wait for tx_done per word.
REQ-003 Parameter MAX_RETRY, default 2: resends per word after NACK (used only with TX_RETRY_EN).
REQ-004 clk  in  1  single clock, all logic on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request to send one 3-word transaction.
REQ-007 opcode  in  2  operation code: 00 ADD, 01 SUB, 10 MULT, 11 reserved.
REQ-008 operand1, operand2  in  32 each  transaction operands.
REQ-009 tx_data  out  32  word presented to the I2C master.
REQ-010 tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
REQ-011 tx_done  in  1  one-cycle pulse from the I2C master: word finished.
REQ-012 tx_nack  in  1  valid only with tx_done; 1 means the slave did not acknowledge.
REQ-013 busy  out  1  transaction in progress.
REQ-014 done  out  1  one-cycle pulse: all three words sent.
REQ-015 err  out  1  sticky error flag, cleared by the next accepted start.
REQ-016 word_idx  out  2  current word: 1 opcode, 2 operand1, 3 operand2, 0 idle.
REQ-017 state_out  out  4  encoded FSM state for debug/LED display.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SEND, WAIT, GAP, FINISH, ERROR.
REQ-019 IDLE: start=1 SHALL snapshot opcode, operand1 and operand2, clear err, set word_idx=1, and go to LOAD.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 LOAD SHALL drive tx_data: word 1 = {30'b0, opcode}, word 2 = operand1, word 3 = operand2, then go to SEND.
REQ-022 SEND SHALL pulse tx_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 tx_data SHALL stay stable from LOAD until the matching tx_done.
REQ-024 WAIT with tx_done=1 and tx_nack=0 SHALL go to GAP if word_idx<3, else to FINISH.
REQ-025 WAIT with tx_done=1 and tx_nack=1 SHALL go to ERROR, unless a retry applies (REQ-035).
REQ-026 WAIT SHALL go to ERROR when the timeout counter reaches TIMEOUT_CYCLES without tx_done.
REQ-027 GAP SHALL count GAP_CYCLES cycles, then increment word_idx and go to LOAD.
REQ-028 With GAP_CYCLES=0, GAP SHALL last exactly one cycle.
REQ-029 FINISH SHALL pulse done for one cycle and return to IDLE with word_idx=0.
REQ-030 ERROR SHALL set err=1 and return to IDLE on the next cycle; done SHALL NOT pulse.
REQ-031 tx_done outside WAIT SHALL be ignored.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Latency from start to the first tx_start SHALL be 3 cycles (IDLE, LOAD, SEND).

Reset
REQ-034 rst_n=0 SHALL force state IDLE, with tx_data=0, tx_start=0, busy=0, done=0, err=0, word_idx=0 and all counters 0.
- This applies at any time, including mid-word; a partial transaction SHALL be abandoned without done.

Configuration
REQ-035 With TX_RETRY_EN defined, a NACK SHALL return the FSM to SEND for the same word, up to MAX_RETRY times per word.
- The retry count resets for each word.
- Exhausting MAX_RETRY SHALL go to ERROR.
- Without TX_RETRY_EN, any NACK SHALL go directly to ERROR, and the retry counter SHALL NOT exist.

Structure
REQ-036 Shared package SHALL hold the state encodings, the opcode constants (ADD, SUB, MULT, RSVD) and the word-index constants 1..3, so the slave-side FSM uses the same values.
REQ-037 One sub-module, tx_gap_timer, SHALL implement the shared GAP/timeout down-counter with load and expire outputs.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- start, opcode=10, operand1=0x40400000, operand2=0x40000000, each tx_done 5 cycles after tx_start -> tx_data sequence 0x00000002, 0x40400000, 0x40000000; three tx_start pulses spaced ≥ GAP_CYCLES; one done pulse; err=0.
- start reasserted while busy=1 -> ignored; exactly three words sent.
- tx_nack=1 on word 2, macro undefined -> err=1, no done, only two tx_start pulses, busy drops.
- TX_RETRY_EN defined, MAX_RETRY=2, NACK twice on word 3 then ACK -> five tx_start pulses total, done=1, err=0.
- tx_done never arrives, TIMEOUT_CYCLES=100 -> err=1 exactly 100 cycles after the first tx_start.
- rst_n pulled low during WAIT of word 2 -> all outputs 0 immediately; a following start sends a full 3-word transaction.

Source files
------------

// File: rtl/master_tx_sequencer_pkg.sv
// Shared encodings for the transaction sequencer and its slave-side counterpart.
// Latency: n/a (types, constants and a pure word-select helper only).
// Backpressure: n/a.
package master_tx_sequencer_pkg;

    // FSM state encoding, also exported on state_out for LED/debug display
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_SEND   = 4'd2,
        ST_WAIT   = 4'd3,
        ST_GAP    = 4'd4,
        ST_FINISH = 4'd5,
        ST_ERROR  = 4'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MULT = 2'b10,
        OP_RSVD = 2'b11
    } opcode_t;

    // Word positions inside one transaction; 0 means no word in flight
    localparam logic [1:0] WORD_NONE     = 2'd0;
    localparam logic [1:0] WORD_OPCODE   = 2'd1;
    localparam logic [1:0] WORD_OPERAND1 = 2'd2;
    localparam logic [1:0] WORD_OPERAND2 = 2'd3;

    // Payload of word idx for a given opcode/operand set
    function automatic logic [31:0] word_sel(input logic [1:0]  idx,
                                             input logic [1:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] w;
        case (idx)
            WORD_OPCODE:   w = {30'b0, op};
            WORD_OPERAND1: w = a;
            WORD_OPERAND2: w = b;
            default:       w = 32'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/master_tx_sequencer_if.sv
// Word handshake between the sequencer and the I2C master engine.
// Latency: tx_start is a one-cycle request; tx_done/tx_nack answer it any number of cycles later.
// Backpressure: the sequencer holds tx_data and issues nothing new until tx_done returns.
interface master_tx_sequencer_if;
    logic [31:0] tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        tx_nack;

    modport master (output tx_data, output tx_start, input tx_done, input tx_nack);
    modport slave  (input tx_data, input tx_start, output tx_done, output tx_nack);
endinterface

// File: rtl/master_tx_sequencer_tx_gap_timer.sv
// Down-counter shared by the inter-word gap and the per-word tx_done timeout.
// Latency: expire is high in the last counted cycle, load_val cycles after the load edge.
// Backpressure: none; load always wins over counting.
module tx_gap_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // A count of 1 is the final cycle of the window; 0 means already elapsed
    assign expire = (cnt <= W'(1));

endmodule

// File: rtl/master_tx_sequencer.sv
// Sends a 3-word transaction (opcode, operand1, operand2) to an I2C master; optional TX_RETRY_EN resends NACKed words.
// Latency: first tx_start in the third cycle counting the start cycle; GAP_CYCLES idle cycles (min 1) between words.
// Backpressure: one word outstanding; waits up to TIMEOUT_CYCLES for tx_done, start ignored while busy.
module master_tx_sequencer #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   opcode,
    input  logic [31:0]                  operand1,
    input  logic [31:0]                  operand2,
    master_tx_sequencer_if.master        tx,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   word_idx,
    output logic [3:0]                   state_out
);
    import master_tx_sequencer_pkg::*;

    // A zero-length window still occupies one cycle of the FSM
    localparam logic [31:0] GAP_LOAD     = (GAP_CYCLES == 0) ? 32'd1 : 32'(GAP_CYCLES);
    localparam logic [31:0] TIMEOUT_LOAD = (TIMEOUT_CYCLES == 0) ? 32'd1 : 32'(TIMEOUT_CYCLES);

    seq_state_t  state;
    logic [1:0]  opcode_q;
    logic [31:0] operand1_q;
    logic [31:0] operand2_q;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_expire;
    logic        retry_ok;

    // Timeout window opens with tx_start (entry to SEND); gap window opens on an ACK
    always_comb begin
        tmr_load = (state == ST_LOAD) || ((state == ST_WAIT) && tx.tx_done);
        tmr_val  = ((state == ST_LOAD) || tx.tx_nack) ? TIMEOUT_LOAD : GAP_LOAD;
    end

    tx_gap_timer #(.W(32)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

`ifdef TX_RETRY_EN
    logic [31:0] retry_cnt;

    // Resends used on the current word; cleared each time a new word is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (state == ST_LOAD) begin
            retry_cnt <= '0;
        end else if ((state == ST_WAIT) && tx.tx_done && tx.tx_nack && retry_ok) begin
            retry_cnt <= retry_cnt + 32'd1;
        end
    end

    assign retry_ok = (retry_cnt < 32'(MAX_RETRY));
`else
    // Without retries every NACK is fatal; MAX_RETRY has no effect in this build
    logic unused_max_retry;
    assign unused_max_retry = |32'(MAX_RETRY);
    assign retry_ok         = 1'b0;
`endif

    // Main sequencer: outputs are registered together with the transition into the state that owns them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            opcode_q    <= '0;
            operand1_q  <= '0;
            operand2_q  <= '0;
            tx.tx_data  <= '0;
            tx.tx_start <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_idx    <= WORD_NONE;
        end else begin
            tx.tx_start <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opcode_q   <= opcode;
                        operand1_q <= operand1;
                        operand2_q <= operand2;
                        err        <= 1'b0;
                        word_idx   <= WORD_OPCODE;
                        tx.tx_data <= word_sel(WORD_OPCODE, opcode, operand1, operand2);
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx.tx_start <= 1'b1;
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx.tx_done) begin
                        if (!tx.tx_nack) begin
                            done  <= (word_idx == WORD_OPERAND2);
                            state <= (word_idx == WORD_OPERAND2) ? ST_FINISH : ST_GAP;
                        end else if (retry_ok) begin
                            tx.tx_start <= 1'b1;
                            state       <= ST_SEND;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end
                    end else if (tmr_expire) begin
                        err   <= 1'b1;
                        state <= ST_ERROR;
                    end
                end
                ST_GAP: begin
                    if (tmr_expire) begin
                        word_idx   <= word_idx + 2'd1;
                        tx.tx_data <= word_sel(word_idx + 2'd1, opcode_q, operand1_q, operand2_q);
                        state      <= ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    word_idx <= WORD_NONE;
                    state    <= ST_IDLE;
                end
                ST_ERROR: begin
                    word_idx <= WORD_NONE;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_master_tx_sequencer.sv
// Bench for master_tx_sequencer: directed scenarios plus randomized transactions against a word-list model.
// Latency: a responder answers each tx_start with tx_done after a programmable delay.
// Backpressure: the responder can withhold tx_done entirely to exercise the timeout.
module tb_master_tx_sequencer;
    import master_tx_sequencer_pkg::*;

    localparam int GAP = 3;
    localparam int TMO = 100;
    localparam int MR  = 2;
`ifdef TX_RETRY_EN
    localparam int RETRIES = MR;
`else
    localparam int RETRIES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  word_idx;
    logic [3:0]  state_out;

    master_tx_sequencer_if tx_if ();

    master_tx_sequencer #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .tx        (tx_if),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_idx  (word_idx),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder / monitor state
    bit          resp_en    = 1'b1;
    int          resp_delay = 5;
    bit          nack_q[$];
    int          st_cyc[$];
    logic [31:0] st_data[$];
    int          ack_cyc[$];
    logic [31:0] ack_data[$];
    int          done_cnt   = 0;
    int          err_cyc    = -1;
    logic        err_prev   = 1'b0;
    int          start_cyc  = 0;

    // I2C-master stand-in: answers each tx_start after resp_delay cycles and logs activity
    initial begin : responder
        int cnt;
        cnt = 0;
        tx_if.tx_done = 1'b0;
        tx_if.tx_nack = 1'b0;
        forever begin
            @(negedge clk);
            tx_if.tx_done = 1'b0;
            tx_if.tx_nack = 1'b0;
            if (rst_n !== 1'b1) begin
                cnt = 0;
            end else if (tx_if.tx_start === 1'b1) begin
                st_cyc.push_back(cyc);
                st_data.push_back(tx_if.tx_data);
                cnt = resp_en ? resp_delay : 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_if.tx_done = 1'b1;
                    tx_if.tx_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                    ack_cyc.push_back(cyc);
                    ack_data.push_back(tx_if.tx_data);
                end
            end
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1 && err_prev !== 1'b1) err_cyc = cyc;
            err_prev = err;
        end
    end

    task automatic clear_logs();
        st_cyc.delete();
        st_data.delete();
        ack_cyc.delete();
        ack_data.delete();
        nack_q.delete();
        done_cnt = 0;
        err_cyc  = -1;
    endtask

    // One-cycle start; inputs are scrambled afterwards so a missing snapshot shows up
    task automatic pulse_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode    = op;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        opcode   = ~op;
        operand1 = ~a;
        operand2 = ~b;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; opcode = '0; operand1 = '0; operand2 = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx_if.tx_data, tx_if.tx_start, busy, done, err, word_idx, state_out} !== 42'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: data=%h start=%b busy=%b done=%b err=%b idx=%0d st=%0d, required all 0",
                     tx_if.tx_data, tx_if.tx_start, busy, done, err, word_idx, state_out);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || tx_if.tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_release: busy=%b tx_start=%b, required 0/0", busy, tx_if.tx_start); end
    endtask

    task automatic test_mult_directed();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0000_0002; exp_w[1] = 32'h4040_0000; exp_w[2] = 32'h4000_0000;
        clear_logs(); resp_delay = 5;
        pulse_start(OP_MULT, 32'h4040_0000, 32'h4000_0000);
        wait_idle("mult");
        vectors++;
        if (st_data.size() != 3) begin miscompares++; $display("FAIL mult_starts: got %0d tx_start, required 3", st_data.size()); end
        if (st_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (st_data[i] !== exp_w[i]) begin miscompares++; $display("FAIL mult_word%0d: got %h, required %h", i + 1, st_data[i], exp_w[i]); end
            end
            vectors++;
            if (st_cyc[0] - start_cyc != 2) begin miscompares++; $display("FAIL mult_latency: got %0d, required 2", st_cyc[0] - start_cyc); end
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (st_cyc[i] - st_cyc[i-1] < GAP || st_cyc[i] - ack_cyc[i-1] != GAP + 2) begin
                    miscompares++;
                    $display("FAIL mult_gap%0d: spacing %0d, ack-to-start %0d, required >=%0d and %0d", i, st_cyc[i] - st_cyc[i-1], st_cyc[i] - ack_cyc[i-1], GAP, GAP + 2);
                end
            end
        end
        vectors++;
        if (done_cnt != 1 || err !== 1'b0) begin miscompares++; $display("FAIL mult_status: done pulses %0d err %b, required 1/0", done_cnt, err); end
        vectors++;
        if (word_idx !== WORD_NONE) begin miscompares++; $display("FAIL mult_word_idx: got %0d, required 0", word_idx); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        clear_logs(); resp_delay = 4;
        pulse_start(OP_ADD, a, b);
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            if (busy === 1'b1) begin
                start = 1'b1; opcode = 2'($urandom); operand1 = $urandom; operand2 = $urandom;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_idle("busy_ign");
        repeat (10) @(negedge clk);
        vectors++;
        if (st_data.size() != 3) begin miscompares++; $display("FAIL busy_ign_starts: got %0d tx_start, required 3", st_data.size()); end
        if (st_data.size() == 3) begin
            vectors++;
            if (st_data[0] !== 32'd0 || st_data[1] !== a || st_data[2] !== b) begin
                miscompares++;
                $display("FAIL busy_ign_words: got %h %h %h, required 00000000 %h %h", st_data[0], st_data[1], st_data[2], a, b);
            end
        end
        vectors++;
        if (done_cnt != 1) begin miscompares++; $display("FAIL busy_ign_done: got %0d done pulses, required 1", done_cnt); end
    endtask

`ifndef TX_RETRY_EN
    task automatic test_nack();
        logic [31:0] a;
        a = $urandom;
        clear_logs(); resp_delay = 3;
        nack_q.push_back(1'b0); nack_q.push_back(1'b1);
        pulse_start(OP_SUB, a, 32'h5555_AAAA);
        wait_idle("nack");
        vectors++;
        if (st_data.size() != 2) begin miscompares++; $display("FAIL nack_starts: got %0d tx_start, required 2", st_data.size()); end
        vectors++;
        if (err !== 1'b1 || done_cnt != 0) begin miscompares++; $display("FAIL nack_status: err %b done pulses %0d, required 1/0", err, done_cnt); end
        if (st_data.size() == 2) begin
            vectors++;
            if (st_data[1] !== a) begin miscompares++; $display("FAIL nack_word2: got %h, required %h", st_data[1], a); end
        end
    endtask
`else
    task automatic test_retry();
        logic [31:0] b;
        b = $urandom;
        clear_logs(); resp_delay = 3;
        nack_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        pulse_start(OP_ADD, 32'h1111_2222, b);
        wait_idle("retry");
        vectors++;
        if (st_data.size() != 5) begin miscompares++; $display("FAIL retry_starts: got %0d tx_start, required 5", st_data.size()); end
        vectors++;
        if (err !== 1'b0 || done_cnt != 1) begin miscompares++; $display("FAIL retry_status: err %b done pulses %0d, required 0/1", err, done_cnt); end
        if (st_data.size() == 5) begin
            for (int i = 2; i < 5; i++) begin
                vectors++;
                if (st_data[i] !== b) begin miscompares++; $display("FAIL retry_word%0d: got %h, required %h", i, st_data[i], b); end
            end
            vectors++;
            if (st_cyc[3] - ack_cyc[2] != 1) begin miscompares++; $display("FAIL retry_resend_delay: got %0d, required 1", st_cyc[3] - ack_cyc[2]); end
        end
        clear_logs();
        nack_q = '{1'b1, 1'b1, 1'b1};
        pulse_start(OP_SUB, 32'h0, 32'h0);
        wait_idle("retry_exh");
        vectors++;
        if (st_data.size() != MR + 1 || err !== 1'b1 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL retry_exhaust: starts %0d err %b done %0d, required %0d/1/0", st_data.size(), err, done_cnt, MR + 1);
        end
    endtask
`endif

    task automatic test_timeout();
        clear_logs(); resp_en = 1'b0;
        pulse_start(OP_MULT, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear_on_start: got %b, required 0", err); end
        wait_idle("timeout");
        resp_en = 1'b1;
        vectors++;
        if (st_cyc.size() != 1) begin miscompares++; $display("FAIL timeout_starts: got %0d tx_start, required 1", st_cyc.size()); end
        if (st_cyc.size() == 1) begin
            vectors++;
            if (err_cyc - st_cyc[0] != TMO) begin miscompares++; $display("FAIL timeout_cycles: err after %0d, required %0d", err_cyc - st_cyc[0], TMO); end
        end
        vectors++;
        if (err !== 1'b1 || done_cnt != 0) begin miscompares++; $display("FAIL timeout_status: err %b done %0d, required 1/0", err, done_cnt); end
    endtask

    task automatic test_reset_mid_word();
        int n;
        logic [31:0] a, b;
        clear_logs(); resp_delay = 6;
        pulse_start(OP_SUB, 32'h1234_5678, 32'h9ABC_DEF0);
        n = 0;
        while (st_cyc.size() < 2 && n < 500) begin @(negedge clk); n++; end
        vectors++;
        if (st_cyc.size() < 2) begin miscompares++; $display("FAIL rst_mid_reach: got %0d tx_start, required 2", st_cyc.size()); end
        repeat (2) @(negedge clk);
        vectors++;
        if (word_idx !== WORD_OPERAND1) begin miscompares++; $display("FAIL rst_mid_idx: got %0d, required 2", word_idx); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({tx_if.tx_data, tx_if.tx_start, busy, done, err, word_idx, state_out} !== 42'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: data=%h start=%b busy=%b done=%b err=%b idx=%0d st=%0d, required all 0",
                     tx_if.tx_data, tx_if.tx_start, busy, done, err, word_idx, state_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (done_cnt != 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d done pulses, required 0", done_cnt); end
        clear_logs(); resp_delay = 2;
        a = $urandom; b = $urandom;
        pulse_start(OP_ADD, a, b);
        wait_idle("rst_mid_after");
        vectors++;
        if (st_data.size() != 3 || done_cnt != 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_resume: starts %0d done %0d err %b, required 3/1/0", st_data.size(), done_cnt, err);
        end
        if (st_data.size() == 3) begin
            vectors++;
            if (st_data[1] !== a || st_data[2] !== b) begin miscompares++; $display("FAIL rst_mid_words: got %h %h, required %h %h", st_data[1], st_data[2], a, b); end
        end
    endtask

    // Random transactions: the model expands each word into (nacks+1) sends, cut short by an unrecoverable NACK
    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [1:0]  op;
            logic [31:0] w [3];
            int          nk [3];
            logic [31:0] exp_q[$];
            int          exp_k[$];
            bit          exp_err;
            op = 2'($urandom_range(0, 3));
            w[0] = {30'b0, op}; w[1] = $urandom; w[2] = $urandom;
            clear_logs();
            resp_delay = $urandom_range(1, 8);
            for (int k = 0; k < 3; k++) begin
                nk[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                repeat (nk[k]) nack_q.push_back(1'b1);
                nack_q.push_back(1'b0);
            end
            exp_err = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!exp_err) begin
                    if (nk[k] > RETRIES) begin
                        repeat (RETRIES + 1) begin exp_q.push_back(w[k]); exp_k.push_back(k); end
                        exp_err = 1'b1;
                    end else begin
                        repeat (nk[k] + 1) begin exp_q.push_back(w[k]); exp_k.push_back(k); end
                    end
                end
            end
            pulse_start(op, w[1], w[2]);
            wait_idle("rand");
            vectors++;
            if (st_data.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_starts: got %0d, required %0d", t, st_data.size(), exp_q.size()); end
            if (st_data.size() == exp_q.size() && st_data.size() > 0) begin
                vectors++;
                if (st_cyc[0] - start_cyc != 2) begin miscompares++; $display("FAIL rand%0d_latency: got %0d, required 2", t, st_cyc[0] - start_cyc); end
                for (int i = 0; i < exp_q.size(); i++) begin
                    vectors++;
                    if (st_data[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_word%0d: got %h, required %h", t, i, st_data[i], exp_q[i]); end
                    if (i < ack_data.size()) begin
                        vectors++;
                        if (ack_data[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_hold%0d: at tx_done %h, required %h", t, i, ack_data[i], exp_q[i]); end
                    end
                    if (i > 0 && i - 1 < ack_cyc.size()) begin
                        vectors++;
                        if (st_cyc[i] - ack_cyc[i-1] != ((exp_k[i] == exp_k[i-1]) ? 1 : GAP + 2)) begin
                            miscompares++;
                            $display("FAIL rand%0d_spacing%0d: got %0d, required %0d", t, i, st_cyc[i] - ack_cyc[i-1], (exp_k[i] == exp_k[i-1]) ? 1 : GAP + 2);
                        end
                    end
                end
            end
            vectors++;
            if (err !== exp_err || done_cnt != (exp_err ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rand%0d_status: err %b done %0d, required %b/%0d", t, err, done_cnt, exp_err, exp_err ? 0 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_busy_ignore();
`ifndef TX_RETRY_EN
        test_nack();
`else
        test_retry();
`endif
        test_timeout();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
